// File: rtl/nem_ohmux_pkg.sv
// Shared types and sizing helpers for the break-before-make NEM relay mux.
package nem_ohmux_pkg;

    typedef enum logic [1:0] {
        StOff,
        StBreak,
        StMake,
        StOn
    } relay_state_e;

    function automatic int unsigned cnt_width(input int unsigned bbm, input int unsigned settle);
        int unsigned mx;
        mx = (bbm > settle) ? bbm : settle;
        return $clog2(mx + 1);
    endfunction

endpackage

// File: rtl/nem_relay_timer.sv
// Loadable down-counter shared by the release and settle intervals.
module nem_relay_timer #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             CP,
    input  logic             CDN,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge CP or negedge CDN) begin
        if (!CDN) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/nem_ohmux_seq.sv
// One-hot NEM relay mux with a registered, break-before-make sequenced select driver.
module nem_ohmux_seq
    import nem_ohmux_pkg::*;
#(
    parameter int unsigned N_IN          = 4,
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned BBM_CYCLES    = 3,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter bit          INVERT        = 1'b1
) (
    input  logic                     CP,
    input  logic                     CDN,
    input  logic                     SEL_VALID,
    output logic                     SEL_READY,
    input  logic [$clog2(N_IN)-1:0]  SEL_IDX,
    input  logic                     SEL_OFF,
    input  logic [N_IN*WIDTH-1:0]    I,
    output logic [N_IN-1:0]          S,
    output logic [WIDTH-1:0]         ZN,
    output logic                     OUT_VALID,
    output logic                     ERR
);

    localparam int unsigned IW    = $clog2(N_IN);
    localparam int unsigned CNT_W = cnt_width(BBM_CYCLES, SETTLE_CYCLES);

    localparam logic [CNT_W-1:0] BBM_LOAD    = CNT_W'(BBM_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IW:0]      N_IN_EXT    = (IW + 1)'(N_IN);
    localparam logic [N_IN-1:0]  ONE         = N_IN'(1);

    relay_state_e     state_q, state_d;
    logic [N_IN-1:0]  s_q, s_d;
    logic             ov_q, ov_d;
    logic             err_q, err_d;
    logic [IW-1:0]    pend_idx_q, pend_idx_d;
    logic             pend_off_q, pend_off_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_val;
    logic             tmr_en;
    logic             tmr_done;
    logic             accept;
    logic             bad_idx;

    assign SEL_READY = (state_q == StOff) || (state_q == StOn);
    assign accept    = SEL_VALID && SEL_READY;
    assign bad_idx   = !SEL_OFF && ({1'b0, SEL_IDX} >= N_IN_EXT);

    nem_relay_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .CP       (CP),
        .CDN      (CDN),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .en       (tmr_en),
        .done     (tmr_done)
    );

    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        ov_d         = ov_q;
        err_d        = 1'b0;
        pend_idx_d   = pend_idx_q;
        pend_off_d   = pend_off_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_en       = 1'b0;

        unique case (state_q)
            StOff: begin
                if (accept) begin
                    if (bad_idx) begin
                        err_d = 1'b1;
                    end else if (!SEL_OFF) begin
                        // Relays are already open, so no release interval is needed.
                        state_d      = StMake;
                        s_d          = ONE << SEL_IDX;
                        pend_idx_d   = SEL_IDX;
                        pend_off_d   = 1'b0;
                        tmr_load     = 1'b1;
                        tmr_load_val = SETTLE_LOAD;
                    end
                end
            end
            StOn: begin
                if (accept) begin
                    if (bad_idx) begin
                        err_d = 1'b1;
                    end else if (SEL_OFF || (SEL_IDX != pend_idx_q)) begin
                        state_d      = StBreak;
                        s_d          = '0;
                        ov_d         = 1'b0;
                        pend_idx_d   = SEL_IDX;
                        pend_off_d   = SEL_OFF;
                        tmr_load     = 1'b1;
                        tmr_load_val = BBM_LOAD;
                    end
                end
            end
            StBreak: begin
                if (tmr_done) begin
                    if (pend_off_q) begin
                        state_d = StOff;
                    end else begin
                        state_d      = StMake;
                        s_d          = ONE << pend_idx_q;
                        tmr_load     = 1'b1;
                        tmr_load_val = SETTLE_LOAD;
                    end
                end else begin
                    tmr_en = 1'b1;
                end
            end
            StMake: begin
                if (tmr_done) begin
                    state_d = StOn;
                    ov_d    = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            default: begin
                state_d = StOff;
                s_d     = '0;
                ov_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CP or negedge CDN) begin
        if (!CDN) begin
            state_q    <= StOff;
            s_q        <= '0;
            ov_q       <= 1'b0;
            err_q      <= 1'b0;
            pend_idx_q <= '0;
            pend_off_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            ov_q       <= ov_d;
            err_q      <= err_d;
            pend_idx_q <= pend_idx_d;
            pend_off_q <= pend_off_d;
        end
    end

    assign S         = s_q;
    assign OUT_VALID = ov_q;
    assign ERR       = err_q;

    a_s_onehot0: assert property (@(posedge CP) disable iff (!CDN) $onehot0(s_q));

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic [N_IN-1:0] hit;
        for (genvar k = 0; k < N_IN; k++) begin : g_in
            assign hit[k] = s_q[k] & I[k*WIDTH + b];
        end
        assign ZN[b] = INVERT ? ~(|hit) : (|hit);
    end

endmodule

// File: tb/tb_nem_ohmux_seq.sv
// Bench for nem_ohmux_seq: three configurations checked every cycle against a timeline model.
module tb_nem_ohmux_seq;

    logic cp  = 1'b0;
    logic cdn = 1'b0;

    always #5 cp = ~cp;

    // Instance A: defaults. B: wide, non-inverting. C: non-power-of-two inputs, minimal intervals.
    logic        a_valid, a_rdy, a_off, a_ov, a_err;
    logic [1:0]  a_idx;
    logic [31:0] a_i;
    logic [3:0]  s_a;
    logic [7:0]  zn_a;

    logic         b_valid, b_rdy, b_off, b_ov, b_err;
    logic [2:0]   b_idx;
    logic [127:0] b_i;
    logic [7:0]   s_b;
    logic [15:0]  zn_b;

    logic        c_valid, c_rdy, c_off, c_ov, c_err;
    logic [2:0]  c_idx;
    logic [19:0] c_i;
    logic [4:0]  s_c;
    logic [3:0]  zn_c;

    nem_ohmux_seq u_a (
        .CP (cp), .CDN (cdn), .SEL_VALID (a_valid), .SEL_READY (a_rdy), .SEL_IDX (a_idx),
        .SEL_OFF (a_off), .I (a_i), .S (s_a), .ZN (zn_a), .OUT_VALID (a_ov), .ERR (a_err)
    );

    nem_ohmux_seq #(
        .N_IN (8), .WIDTH (16), .BBM_CYCLES (3), .SETTLE_CYCLES (4), .INVERT (1'b0)
    ) u_b (
        .CP (cp), .CDN (cdn), .SEL_VALID (b_valid), .SEL_READY (b_rdy), .SEL_IDX (b_idx),
        .SEL_OFF (b_off), .I (b_i), .S (s_b), .ZN (zn_b), .OUT_VALID (b_ov), .ERR (b_err)
    );

    nem_ohmux_seq #(
        .N_IN (5), .WIDTH (4), .BBM_CYCLES (1), .SETTLE_CYCLES (1), .INVERT (1'b1)
    ) u_c (
        .CP (cp), .CDN (cdn), .SEL_VALID (c_valid), .SEL_READY (c_rdy), .SEL_IDX (c_idx),
        .SEL_OFF (c_off), .I (c_i), .S (s_c), .ZN (zn_c), .OUT_VALID (c_ov), .ERR (c_err)
    );

    // Model tracks which bus is visible and the edge numbers at which pending events land.
    typedef struct {
        int shown;
        bit ov;
        bit rdy;
        bit err;
        int pend;
        int e;
        int make_at;
        int done_at;
    } mdl_t;

    mdl_t m_a, m_b, m_c;
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic mdl_t m_reset();
        mdl_t r;
        r.shown   = -1;
        r.ov      = 1'b0;
        r.rdy     = 1'b1;
        r.err     = 1'b0;
        r.pend    = -1;
        r.e       = 0;
        r.make_at = -1;
        r.done_at = -1;
        return r;
    endfunction

    function automatic mdl_t m_step(input mdl_t m, input bit v, input int idx, input bit off,
                                    input int n, input int bbm, input int settle);
        mdl_t r;
        r     = m;
        r.e   = m.e + 1;
        r.err = 1'b0;
        if (m.rdy) begin
            if (v) begin
                if (!off && idx >= n) begin
                    r.err = 1'b1;
                end else if (m.shown >= 0) begin
                    if (off || idx != m.shown) begin
                        r.shown   = -1;
                        r.ov      = 1'b0;
                        r.rdy     = 1'b0;
                        r.pend    = off ? -1 : idx;
                        r.make_at = r.e + bbm;
                        r.done_at = off ? r.e + bbm : r.e + bbm + settle;
                    end
                end else if (!off) begin
                    r.shown   = idx;
                    r.rdy     = 1'b0;
                    r.pend    = idx;
                    r.make_at = r.e;
                    r.done_at = r.e + settle;
                end
            end
        end else begin
            if (r.e == m.make_at) r.shown = m.pend;
            if (r.e == m.done_at) begin
                r.rdy = 1'b1;
                r.ov  = (m.pend >= 0);
            end
        end
        return r;
    endfunction

    always @(posedge cp or negedge cdn) begin
        if (!cdn) begin
            m_a <= m_reset();
            m_b <= m_reset();
            m_c <= m_reset();
        end else begin
            m_a <= m_step(m_a, a_valid, int'(a_idx), a_off, 4, 3, 4);
            m_b <= m_step(m_b, b_valid, int'(b_idx), b_off, 8, 3, 4);
            m_c <= m_step(m_c, c_valid, int'(c_idx), c_off, 5, 1, 1);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp(input string nm, input mdl_t m, input int w, input bit inv,
                       input logic [127:0] ibus, input logic [7:0] s, input logic [15:0] zn,
                       input logic ov, input logic rdy, input logic err);
        logic [7:0]  es;
        logic [15:0] ez;
        logic [15:0] mask;
        mask = 16'((32'd1 << w) - 1);
        es   = (m.shown < 0) ? 8'd0 : (8'd1 << m.shown);
        ez   = (m.shown < 0) ? 16'd0 : 16'(ibus >> (m.shown * w));
        if (inv) ez = ~ez;
        ez = ez & mask;
        chk({nm, ".S"}, 64'(s), 64'(es));
        chk({nm, ".ZN"}, 64'(zn), 64'(ez));
        chk({nm, ".OUT_VALID"}, 64'(ov), 64'(m.ov));
        chk({nm, ".SEL_READY"}, 64'(rdy), 64'(m.rdy));
        chk({nm, ".ERR"}, 64'(err), 64'(m.err));
    endtask

    always @(negedge cp) begin
        if (cdn === 1'b1) begin
            cmp("A", m_a, 8, 1'b1, 128'(a_i), 8'(s_a), 16'(zn_a), a_ov, a_rdy, a_err);
            cmp("B", m_b, 16, 1'b0, b_i, s_b, zn_b, b_ov, b_rdy, b_err);
            cmp("C", m_c, 4, 1'b1, 128'(c_i), 8'(s_c), 16'(zn_c), c_ov, c_rdy, c_err);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge cp);
        #1;
    endtask

    task automatic req_a(input int idx, input bit off);
        a_valid = 1'b1;
        a_idx   = 2'(idx);
        a_off   = off;
        @(posedge cp);
        #1;
        a_valid = 1'b0;
    endtask

    initial begin
        a_valid = 0; a_idx = 0; a_off = 0;
        b_valid = 0; b_idx = 0; b_off = 0;
        c_valid = 0; c_idx = 0; c_off = 0;
        a_i = {8'h77, 8'hA5, 8'h11, 8'h3C};
        b_i = {$urandom, $urandom, $urandom, $urandom};
        c_i = 20'h5A3C9;

        #12;
        chk("rst.S", 64'(s_a), 64'h0);
        chk("rst.ZN", 64'(zn_a), 64'hFF);
        chk("rst.SEL_READY", 64'(a_rdy), 64'h1);
        chk("rst.OUT_VALID", 64'(a_ov), 64'h0);
        chk("rst.ERR", 64'(a_err), 64'h0);
        @(posedge cp);
        #2 cdn = 1'b1;
        @(posedge cp);
        #1;

        // From OFF: relay closes on the next cycle, valid after the settle interval.
        req_a(2, 1'b0);
        chk("off2.S", 64'(s_a), 64'h4);
        chk("off2.ZN", 64'(zn_a), 64'h5A);
        chk("off2.SEL_READY", 64'(a_rdy), 64'h0);
        step(3);
        chk("off2.ov_early", 64'(a_ov), 64'h0);
        step(1);
        chk("off2.ov", 64'(a_ov), 64'h1);
        chk("off2.rdy", 64'(a_rdy), 64'h1);

        // ON 2 -> 0: three all-open cycles before the new contact closes.
        req_a(0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            chk("bbm.S_open", 64'(s_a), 64'h0);
            chk("bbm.ZN_open", 64'(zn_a), 64'hFF);
            step(1);
        end
        chk("bbm.S", 64'(s_a), 64'h1);
        chk("bbm.ZN", 64'(zn_a), 64'hC3);
        step(3);
        chk("bbm.ov_early", 64'(a_ov), 64'h0);
        step(1);
        chk("bbm.ov", 64'(a_ov), 64'h1);

        req_a(0, 1'b0);
        chk("same.S", 64'(s_a), 64'h1);
        chk("same.ov", 64'(a_ov), 64'h1);
        chk("same.rdy", 64'(a_rdy), 64'h1);

        req_a(0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk("selof.S_open", 64'(s_a), 64'h0);
            chk("selof.rdy", 64'(a_rdy), 64'h0);
            step(1);
        end
        chk("selof.ZN", 64'(zn_a), 64'hFF);
        chk("selof.ov", 64'(a_ov), 64'h0);
        chk("selof.rdy_back", 64'(a_rdy), 64'h1);

        // Reset in the middle of MAKE acts without a clock edge.
        req_a(3, 1'b0);
        chk("make.S", 64'(s_a), 64'h8);
        step(1);
        #2 cdn = 1'b0;
        #1;
        chk("arst.S", 64'(s_a), 64'h0);
        chk("arst.ov", 64'(a_ov), 64'h0);
        chk("arst.rdy", 64'(a_rdy), 64'h1);
        @(posedge cp);
        #2 cdn = 1'b1;
        @(posedge cp);
        #1;

        // Out-of-range index on the five-input instance.
        c_valid = 1'b1; c_idx = 3'd6; c_off = 1'b0;
        @(posedge cp);
        #1;
        c_valid = 1'b0;
        chk("err.pulse", 64'(c_err), 64'h1);
        chk("err.S", 64'(s_c), 64'h0);
        chk("err.rdy", 64'(c_rdy), 64'h1);
        step(1);
        chk("err.clear", 64'(c_err), 64'h0);
        c_valid = 1'b1; c_idx = 3'd7; c_off = 1'b1;
        @(posedge cp);
        #1;
        c_valid = 1'b0;
        chk("off_ignores_idx.ERR", 64'(c_err), 64'h0);

        for (int cyc = 0; cyc < 2000; cyc++) begin
            a_valid = ($urandom_range(0, 2) != 0);
            a_idx   = 2'($urandom_range(0, 3));
            a_off   = ($urandom_range(0, 5) == 0);
            b_valid = ($urandom_range(0, 2) != 0);
            b_idx   = 3'($urandom_range(0, 7));
            b_off   = ($urandom_range(0, 5) == 0);
            c_valid = ($urandom_range(0, 2) != 0);
            c_idx   = 3'($urandom_range(0, 7));
            c_off   = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 7) == 0) begin
                a_i = $urandom;
                b_i = {$urandom, $urandom, $urandom, $urandom};
                c_i = 20'($urandom);
            end
            step(1);
        end

        a_valid = 0; b_valid = 0; c_valid = 0;
        step(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
